// File: rtl/arm_pipe_ctrl_if.sv
// Pipeline-control bundle between the ARM pipeline datapath and arm_pipe_ctrl.
// The master is the datapath side; the slave is the control unit.
interface arm_pipe_ctrl_if #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic              two_src;
  logic [REG_AW-1:0] exe_dest;
  logic              exe_wb_en;
  logic              exe_mem_r_en;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_wb_en;
  logic              branch_taken;
  logic              mem_req;
  logic              mem_ready;
  logic              freeze_if_id;
  logic              freeze_all;
  logic              flush;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic              mem_err;
  logic [CNT_W-1:0]  haz_cnt;
  logic [CNT_W-1:0]  mem_cnt;

  modport master (
    output src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    input  freeze_if_id, freeze_all, flush, sel_a, sel_b, mem_err,
           haz_cnt, mem_cnt
  );

  modport slave (
    input  src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    output freeze_if_id, freeze_all, flush, sel_a, sel_b, mem_err,
           haz_cnt, mem_cnt
  );
endinterface

// File: rtl/arm_pipe_ctrl.sv
// Pipeline control for the five-stage ARM core: hazard stall, forwarding
// selects, memory-wait freeze with timeout, and saturating stall counters.
module arm_pipe_ctrl #(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned FWD_EN  = 1,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200,
  parameter int unsigned CNT_W   = 16
) (
  input logic             clk,
  input logic             rst,
  arm_pipe_ctrl_if.slave  bus
);

  localparam bit FWD_ON = (FWD_EN != 0);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e            state, state_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic              err_set;
  logic              mem_err_q;
  logic [1:0]        sel_a_q, sel_b_q, sel_a_nxt, sel_b_nxt;
  logic [CNT_W-1:0]  haz_cnt_q, mem_cnt_q;

  logic m1_exe, m2_exe, m1_mem, m2_mem;
  logic raw, wait_allowed, freeze_all, freeze_if_id, flush, fwd_exe;

  // Source-register matches against the EXE and MEM producers
  assign m1_exe = (bus.src1 == bus.exe_dest);
  assign m2_exe = bus.two_src & (bus.src2 == bus.exe_dest);
  assign m1_mem = (bus.src1 == bus.mem_dest);
  assign m2_mem = bus.two_src & (bus.src2 == bus.mem_dest);

  // With forwarding only a load in EXE cannot be bypassed
  always_comb begin
    raw = 1'b0;
    if (FWD_ON)
      raw = bus.exe_wb_en & bus.exe_mem_r_en & (m1_exe | m2_exe);
    else
      raw = (bus.exe_wb_en & (m1_exe | m2_exe)) |
            (bus.mem_wb_en & (m1_mem | m2_mem));
  end

  assign wait_allowed = (state == ST_RUN) |
                        ((state == ST_WAIT) & (to_cnt < TO_W'(TIMEOUT)));
  assign freeze_all   = bus.mem_req & ~bus.mem_ready & wait_allowed;
  assign freeze_if_id = raw & ~bus.branch_taken & ~freeze_all;
  assign flush        = bus.branch_taken & ~freeze_all;
  assign fwd_exe      = bus.exe_wb_en & ~bus.exe_mem_r_en;

  // Memory-wait FSM: next state and timeout counter
  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    err_set    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (bus.mem_req & ~bus.mem_ready) begin
          state_nxt  = ST_WAIT;
          to_cnt_nxt = TO_W'(1);
        end
      end
      ST_WAIT: begin
        if (~bus.mem_req | bus.mem_ready) begin
          state_nxt  = ST_RUN;
          to_cnt_nxt = '0;
        end else if (to_cnt == TO_W'(TIMEOUT)) begin
          state_nxt  = ST_ERR;
          to_cnt_nxt = '0;
          err_set    = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      ST_ERR: begin
        if (~bus.mem_req) state_nxt = ST_RUN;
      end
      default: begin
        state_nxt  = ST_RUN;
        to_cnt_nxt = '0;
      end
    endcase
  end

  // Forwarding selects; the EXE producer is younger than MEM and wins
  always_comb begin
    sel_a_nxt = 2'd0;
    sel_b_nxt = 2'd0;
    if (FWD_ON && !(flush || freeze_if_id)) begin
      if (fwd_exe & m1_exe)              sel_a_nxt = 2'd1;
      else if (bus.mem_wb_en & m1_mem)   sel_a_nxt = 2'd2;
      if (fwd_exe & m2_exe)              sel_b_nxt = 2'd1;
      else if (bus.mem_wb_en & m2_mem)   sel_b_nxt = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      to_cnt    <= '0;
      mem_err_q <= 1'b0;
      sel_a_q   <= 2'd0;
      sel_b_q   <= 2'd0;
      haz_cnt_q <= '0;
      mem_cnt_q <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
      if (err_set) mem_err_q <= 1'b1;
      if (!freeze_all) begin
        sel_a_q <= sel_a_nxt;
        sel_b_q <= sel_b_nxt;
      end
      if (freeze_if_id && (haz_cnt_q != {CNT_W{1'b1}}))
        haz_cnt_q <= haz_cnt_q + CNT_W'(1);
      if (freeze_all && (mem_cnt_q != {CNT_W{1'b1}}))
        mem_cnt_q <= mem_cnt_q + CNT_W'(1);
    end
  end

  assign bus.freeze_all   = freeze_all;
  assign bus.freeze_if_id = freeze_if_id;
  assign bus.flush        = flush;
  assign bus.sel_a        = sel_a_q;
  assign bus.sel_b        = sel_b_q;
  assign bus.mem_err      = mem_err_q;
  assign bus.haz_cnt      = haz_cnt_q;
  assign bus.mem_cnt      = mem_cnt_q;

endmodule

// File: tb/tb_arm_pipe_ctrl.sv
// Directed scoreboard bench: a forwarding instance (A) and a stall-only,
// short-timeout, narrow-counter instance (B) share the same stimulus.
module tb_arm_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken, mem_req, mem_ready;

  arm_pipe_ctrl_if #(.REG_AW(4), .CNT_W(16)) bus_a ();
  arm_pipe_ctrl_if #(.REG_AW(4), .CNT_W(4))  bus_b ();

  assign bus_a.src1 = src1;           assign bus_b.src1 = src1;
  assign bus_a.src2 = src2;           assign bus_b.src2 = src2;
  assign bus_a.two_src = two_src;     assign bus_b.two_src = two_src;
  assign bus_a.exe_dest = exe_dest;   assign bus_b.exe_dest = exe_dest;
  assign bus_a.exe_wb_en = exe_wb_en; assign bus_b.exe_wb_en = exe_wb_en;
  assign bus_a.exe_mem_r_en = exe_mem_r_en; assign bus_b.exe_mem_r_en = exe_mem_r_en;
  assign bus_a.mem_dest = mem_dest;   assign bus_b.mem_dest = mem_dest;
  assign bus_a.mem_wb_en = mem_wb_en; assign bus_b.mem_wb_en = mem_wb_en;
  assign bus_a.branch_taken = branch_taken; assign bus_b.branch_taken = branch_taken;
  assign bus_a.mem_req = mem_req;     assign bus_b.mem_req = mem_req;
  assign bus_a.mem_ready = mem_ready; assign bus_b.mem_ready = mem_ready;

  arm_pipe_ctrl #(.REG_AW(4), .FWD_EN(1), .TO_W(8), .TIMEOUT(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  arm_pipe_ctrl #(.REG_AW(4), .FWD_EN(0), .TO_W(8), .TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  localparam int FIF = 0, FALL = 1, FLUSH = 2, SELA = 3, SELB = 4, ERR = 5, HAZ = 6, MEM = 7;
  localparam int A = 0, B = 8;

  typedef struct {
    string tag;
    int    code;
    int    val;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [15:0] obs(input int code);
    case (code)
      A + FIF:   return 16'(bus_a.freeze_if_id);
      A + FALL:  return 16'(bus_a.freeze_all);
      A + FLUSH: return 16'(bus_a.flush);
      A + SELA:  return 16'(bus_a.sel_a);
      A + SELB:  return 16'(bus_a.sel_b);
      A + ERR:   return 16'(bus_a.mem_err);
      A + HAZ:   return 16'(bus_a.haz_cnt);
      A + MEM:   return 16'(bus_a.mem_cnt);
      B + FIF:   return 16'(bus_b.freeze_if_id);
      B + FALL:  return 16'(bus_b.freeze_all);
      B + FLUSH: return 16'(bus_b.flush);
      B + SELA:  return 16'(bus_b.sel_a);
      B + SELB:  return 16'(bus_b.sel_b);
      B + ERR:   return 16'(bus_b.mem_err);
      B + HAZ:   return 16'(bus_b.haz_cnt);
      B + MEM:   return 16'(bus_b.mem_cnt);
      default:   return 16'hxxxx;
    endcase
  endfunction

  task automatic exp_push(input string tag, input int code, input int val);
    exp_t e;
    e.tag = tag; e.code = code; e.val = val;
    q.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [15:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.code);
      n_assert++;
      assert (o === 16'(e.val)) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask

  // Sample mid-low-phase, then advance to the next falling edge
  task automatic step();
    #2 check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    src1 = '0; src2 = '0; two_src = 1'b0; exe_dest = '0; exe_wb_en = 1'b0;
    exe_mem_r_en = 1'b0; mem_dest = '0; mem_wb_en = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    mem_req = 1'b1;
    repeat (2) @(negedge clk);
    exp_push("rst_a_fall", A + FALL, 1); exp_push("rst_b_fall", B + FALL, 1);
    exp_push("rst_a_sela", A + SELA, 0); exp_push("rst_a_haz", A + HAZ, 0);
    exp_push("rst_a_mem", A + MEM, 0);   exp_push("rst_b_err", B + ERR, 0);
    step();

    // ALU producer in EXE: forwarded (A), stalled (B)
    rst = 1'b1; idle();
    exe_dest = 4'd1; exe_wb_en = 1'b1; src1 = 4'd1;
    exp_push("alu_a_fif", A + FIF, 0); exp_push("alu_b_fif", B + FIF, 1);
    step();
    idle();
    exp_push("alu_a_sela", A + SELA, 1); exp_push("alu_b_sela", B + SELA, 0);
    exp_push("alu_a_haz", A + HAZ, 0);   exp_push("alu_b_haz", B + HAZ, 1);
    step();

    // Load-use: one bubble, then forward from WB
    exe_dest = 4'd1; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; src1 = 4'd1;
    exp_push("ld_a_fif", A + FIF, 1); exp_push("ld_b_fif", B + FIF, 1);
    step();
    idle(); mem_dest = 4'd1; mem_wb_en = 1'b1; src1 = 4'd1;
    exp_push("ld2_a_fif", A + FIF, 0); exp_push("ld2_a_haz", A + HAZ, 1);
    exp_push("ld2_a_sela", A + SELA, 0); exp_push("ld2_b_fif", B + FIF, 1);
    step();
    idle();
    exp_push("ld3_a_sela", A + SELA, 2); exp_push("ld3_a_haz", A + HAZ, 1);
    exp_push("ld3_b_haz", B + HAZ, 3);
    step();

    // src2 hazard depends on two_src
    mem_dest = 4'd3; mem_wb_en = 1'b1; src2 = 4'd3; two_src = 1'b1;
    exp_push("s2_b_fif", B + FIF, 1); exp_push("s2_a_fif", A + FIF, 0);
    step();
    two_src = 1'b0;
    exp_push("s2off_b_fif", B + FIF, 0); exp_push("s2_a_selb", A + SELB, 2);
    step();

    // Both producers match: youngest (EXE) wins
    idle(); exe_dest = 4'd4; exe_wb_en = 1'b1; mem_dest = 4'd4; mem_wb_en = 1'b1;
    src1 = 4'd4; src2 = 4'd4; two_src = 1'b1;
    exp_push("yng_a_fif", A + FIF, 0); exp_push("yng_b_fif", B + FIF, 1);
    exp_push("s2off_a_selb", A + SELB, 0);
    step();
    idle();
    exp_push("yng_a_sela", A + SELA, 1); exp_push("yng_a_selb", A + SELB, 1);
    exp_push("yng_b_haz", B + HAZ, 5);
    step();

    // Memory wait; B times out after 4 cycles, A released by ready after 5
    mem_req = 1'b1;
    exp_push("mw1_a_fall", A + FALL, 1); exp_push("mw1_b_fall", B + FALL, 1);
    step();
    exp_push("mw2_a_fall", A + FALL, 1); exp_push("mw2_b_fall", B + FALL, 1);
    step();
    branch_taken = 1'b1; exe_dest = 4'd2; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; src1 = 4'd2;
    for (int i = 3; i <= 4; i++) begin
      exp_push("mwbr_a_fall", A + FALL, 1); exp_push("mwbr_a_flush", A + FLUSH, 0);
      exp_push("mwbr_a_fif", A + FIF, 0);   exp_push("mwbr_b_fall", B + FALL, 1);
      exp_push("mwbr_b_flush", B + FLUSH, 0);
      step();
    end
    exp_push("mw5_a_fall", A + FALL, 1); exp_push("mw5_a_flush", A + FLUSH, 0);
    exp_push("to_b_fall", B + FALL, 0);  exp_push("to_b_flush", B + FLUSH, 1);
    exp_push("to_b_fif", B + FIF, 0);    exp_push("to_b_err_pre", B + ERR, 0);
    step();
    mem_ready = 1'b1;
    exp_push("rdy_a_fall", A + FALL, 0); exp_push("rdy_a_flush", A + FLUSH, 1);
    exp_push("rdy_a_fif", A + FIF, 0);   exp_push("rdy_a_mem", A + MEM, 5);
    exp_push("rdy_a_err", A + ERR, 0);   exp_push("to_b_err", B + ERR, 1);
    exp_push("to_b_mem", B + MEM, 4);    exp_push("to_b_haz", B + HAZ, 5);
    exp_push("rdy_a_haz", A + HAZ, 1);
    step();
    idle();
    exp_push("post_a_sela", A + SELA, 0); exp_push("post_b_fall", B + FALL, 0);
    step();
    mem_req = 1'b1;
    exp_push("rerun_b_fall", B + FALL, 1); exp_push("rerun_a_fall", A + FALL, 1);
    step();
    mem_ready = 1'b1;
    exp_push("rerun_a_mem", A + MEM, 6); exp_push("rerun_b_mem", B + MEM, 5);
    exp_push("rerun_b_fall0", B + FALL, 0); exp_push("sticky_b_err", B + ERR, 1);
    step();

    // Saturate B's 4-bit hazard counter
    idle(); exe_dest = 4'd6; exe_wb_en = 1'b1; src1 = 4'd6;
    for (int i = 0; i < 20; i++) begin
      exp_push("sat_b_fif", B + FIF, 1); exp_push("sat_a_fif", A + FIF, 0);
      step();
    end
    idle();
    exp_push("sat_b_haz", B + HAZ, 15); exp_push("sat_a_haz", A + HAZ, 1);
    step();

    // Reset in the middle of a memory wait
    mem_req = 1'b1;
    step();
    #3 rst = 1'b0;
    #1;
    exp_push("arst_a_haz", A + HAZ, 0); exp_push("arst_a_mem", A + MEM, 0);
    exp_push("arst_b_haz", B + HAZ, 0); exp_push("arst_b_mem", B + MEM, 0);
    exp_push("arst_b_err", B + ERR, 0); exp_push("arst_a_sela", A + SELA, 0);
    exp_push("arst_a_fall", A + FALL, 1);
    check_all();
    @(negedge clk);
    rst = 1'b1; idle();
    exp_push("end_a_fall", A + FALL, 0); exp_push("end_a_mem", A + MEM, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
